// File: rtl/m_div8_seq.sv
// Sequential radix-2 non-restoring divider with start/busy/done handshake.
// Define M_DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module m_div8_seq #(
  parameter int unsigned NAND_TIME = 7,
  parameter int unsigned WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // NAND_TIME only annotates gate delay for timing models; it has no synthesizable effect.
  if (WIDTH < 4 || WIDTH > 16 || NAND_TIME == 0) begin : g_param_check
    $error("m_div8_seq: WIDTH must be 4..16 and NAND_TIME non-zero");
  end

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             dbz_d;

  logic [WIDTH-1:0] dvd_mag, dsr_mag, rem_mag, quo_res, rem_res;
  logic [WIDTH:0]   shifted, addsub;
  logic             accept;

  assign accept  = (state_q == StIdle) && start;
  assign shifted = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  // Non-restoring step: the sign of the running remainder selects add or subtract.
  assign addsub  = prem_q[WIDTH] ? shifted + {1'b0, dsr_q} : shifted - {1'b0, dsr_q};
  assign rem_mag = prem_q[WIDTH] ? prem_q[WIDTH-1:0] + dsr_q : prem_q[WIDTH-1:0];

`ifdef M_DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign quo_res = neg_quo_q ? -quo_q : quo_q;
  assign rem_res = neg_rem_q ? -rem_mag : rem_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign quo_res = quo_q;
  assign rem_res = rem_mag;
`endif

  always_comb begin
    state_d     = state_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          prem_d = '0;
          quo_d  = dvd_mag;
          dsr_d  = dsr_mag;
          cnt_d  = CntW'(WIDTH - 1);
          if (divisor == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = StIter;
          end
        end
      end
      StIter: begin
        prem_d = addsub;
        quo_d  = {quo_q[WIDTH-2:0], ~addsub[WIDTH]};
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFix;
      end
      StFix: begin
        quotient_d  = quo_res;
        remainder_d = rem_res;
        dbz_d       = 1'b0;
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prem_q      <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      cnt_q       <= cnt_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
    end
  end

  assign busy = (state_q == StIter) || (state_q == StFix);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_m_div8_seq.sv
// Bench for m_div8_seq: latency/arithmetic model checked every cycle plus directed literals.
module tb_m_div8_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  m_div8_seq #(
    .NAND_TIME(7),
    .WIDTH    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: truncating division, remainder follows the dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
`ifdef M_DIV_SIGNED_EN
    int sa, sb;
`endif
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef M_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Cycle model: an accepted request finishes a fixed number of edges later.
  logic [W-1:0] e_q = '0, e_r = '0, p_q = '0, p_r = '0;
  logic         e_z = 1'b0, p_z = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  bit           pend = 1'b0, idle_ok;
  int           left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      e_q = '0; e_r = '0; e_z = 1'b0; e_busy = 1'b0; e_done = 1'b0; pend = 1'b0;
    end else begin
      idle_ok = !pend && !e_done;
      e_done  = 1'b0;
      e_busy  = 1'b0;
      if (idle_ok && start) begin
        pend = 1'b1;
        model(dividend, divisor, p_q, p_r, p_z);
        left = (divisor == '0) ? 0 : W + 1;
      end else if (pend) begin
        left--;
      end
      if (pend) begin
        if (left == 0) begin
          e_done = 1'b1;
          pend   = 1'b0;
          e_q    = p_q;
          e_r    = p_r;
          e_z    = p_z;
        end else begin
          e_busy = 1'b1;
        end
      end
    end
    #1;
    check("cyc busy", busy, e_busy);
    check("cyc done", done, e_done);
    check("cyc quotient", quotient, e_q);
    check("cyc remainder", remainder, e_r);
    check("cyc div_by_zero", div_by_zero, e_z);
  end

  // lat = edge index (accept edge is 0) at whose sample done is first seen high.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a, b, q, r;
    logic         z;
  } vec_t;

`ifdef M_DIV_SIGNED_EN
  localparam vec_t Vecs [8] = '{
    '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0},
    '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1},
    '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0},
    '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0},
    '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0},
    '{8'hC8, 8'h03, 8'hEE, 8'hFE, 1'b0},
    '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0},
    '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0}
  };
`else
  localparam vec_t Vecs [8] = '{
    '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0},
    '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1},
    '{8'h9C, 8'h07, 8'h16, 8'h02, 1'b0},
    '{8'h64, 8'hF9, 8'h00, 8'h64, 1'b0},
    '{8'h80, 8'hFF, 8'h00, 8'h80, 1'b0},
    '{8'hC8, 8'h03, 8'h42, 8'h02, 1'b0},
    '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0},
    '{8'h9C, 8'hF9, 8'h00, 8'h9C, 1'b0}
  };
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, '0);
    check("reset remainder", remainder, '0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_div(Vecs[i].a, Vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), lat, Vecs[i].z ? 1 : 10);
      check($sformatf("vec%0d quotient", i), quotient, Vecs[i].q);
      check($sformatf("vec%0d remainder", i), remainder, Vecs[i].r);
      check($sformatf("vec%0d div_by_zero", i), div_by_zero, Vecs[i].z);
    end

    // A second start four edges into a division must be dropped.
    @(negedge clk);
    dividend = 8'h64;
    divisor  = 8'h07;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    dividend = 8'h11;
    divisor  = 8'h02;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat++;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignored-start latency", lat, 10);
    check("ignored-start quotient", quotient, 8'h0E);
    check("ignored-start remainder", remainder, 8'h02);

    // Asynchronous reset five edges into a division.
    @(negedge clk);
    dividend = 8'hC8;
    divisor  = 8'h03;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset quotient", quotient, '0);
    check("midreset remainder", remainder, '0);
    check("midreset div_by_zero", div_by_zero, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_div(8'hFF, 8'h01, lat);
    check("post-reset latency", lat, 10);
    check("post-reset quotient", quotient, 8'hFF);
    check("post-reset remainder", remainder, 8'h00);

    // Random operands, checked by the cycle model only.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 3) ? '0 : W'($urandom);
      run_div(ra, rb, lat);
      check($sformatf("rand%0d latency", i), lat, (rb == '0) ? 1 : 10);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
